// File: rtl/uart_prog_loader_pkg.sv
// Shared encodings and UART frame constants for the program loader.
package uart_prog_loader_pkg;

  localparam int unsigned DataBits  = 8;
  localparam int unsigned StopBits  = 1;
  localparam int unsigned FrameBits = DataBits + StopBits;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  typedef enum logic [1:0] {StLoad, StCheck, StRun, StError} top_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop input synchronizer and start-bit glitch rejection.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(FrameBits);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

  logic [1:0]          sync_q;
  logic                rx_s;
  rx_state_e           state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DataBits-1:0] shift_q, shift_d;

  assign rx_s     = sync_q[1];
  assign byte_out = shift_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b11;
      state_q <= RxIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = RxStart;
      end
      RxStart: begin
        // A line back high at mid start bit is a glitch, not a frame.
        if (cnt_q == HalfM1) begin
          cnt_d   = '0;
          state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DataBits-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxW'(DataBits - 1)) state_d = RxStop;
        end
      end
      RxStop: begin
        if (cnt_q == FullM1) begin
          cnt_d = '0;
          if (!rx_s) begin
            frame_err = 1'b1;
            state_d   = RxIdle;
          end else if (idx_q == IdxW'(FrameBits - 1)) begin
            byte_valid = 1'b1;
            state_d    = RxIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads CELL_NUMBERS little-endian 32-bit words from UART into instruction memory, then
// releases the CPU. Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CELL_NUMBERS = 64,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(CELL_NUMBERS - 1);

  logic [7:0]        rx_byte;
  logic              rx_valid, rx_ferr;
  top_state_e        state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .byte_out  (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_ferr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StLoad;
      bcnt_q  <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      StLoad: begin
        if (rx_ferr) begin
          state_d = StError;
        end else if (rx_valid) begin
          word_d = {rx_byte, word_q[23:8]};
          bcnt_d = bcnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = sum_q + rx_byte;
`endif
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {rx_byte, word_q};
          end
        end
        // Address advances after each write; it parks on the last cell rather than wrapping.
        if (we_q) begin
          if (addr_q == LastAddr) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StRun;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (rx_ferr) state_d = StError;
        else if (rx_valid) state_d = (rx_byte == sum_q) ? StRun : StError;
      end
`endif
      default: ;
    endcase
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = (state_q != StRun);
  assign load_done  = (state_q == StRun);
  assign load_err   = (state_q == StError);

endmodule
